// File: rtl/text_vram_writer_pkg.sv
// ============================================================================
// text_pkg : shared constants, state encoding and word packing for the text VRAM
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package text_pkg;
  localparam int COLS        = 80;
  localparam int ROWS        = 30;
  localparam int COL_BITS    = 7;
  localparam int ROW_BITS    = 5;
  localparam int ADDR_BITS   = 13;
  localparam int VRAM_WORDS  = 8192;
  localparam int CLEAR_WORDS = 1 << (ROW_BITS + COL_BITS);

  localparam logic [7:0] BLANK_CHAR = 8'h20;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_BS    = 8'h08;

  typedef enum logic [1:0] {
    CLEAR_ALL = 2'd0,
    IDLE      = 2'd1,
    CLEAR_ROW = 2'd2
  } state_t;

  function automatic logic [15:0] pack_word(input logic [7:0] attr, input logic [7:0] ch);
    return {attr, ch};
  endfunction

  // Row stride is 128 words; bit 12 stays zero for the text plane.
  function automatic logic [ADDR_BITS-1:0] vram_addr(input logic [ROW_BITS-1:0] row,
                                                     input logic [COL_BITS-1:0] col);
    return {1'b0, row, col};
  endfunction
endpackage

`default_nettype wire

// File: rtl/text_vram_writer_if.sv
// ============================================================================
// text_char_if / text_vmem_if : character stream handshake and VRAM write port
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface text_char_if;
  logic       in_char_valid;
  logic [7:0] in_char_data;
  logic [7:0] in_attr;
  logic       out_char_ready;

  modport master (output in_char_valid, in_char_data, in_attr, input out_char_ready);
  modport slave  (input in_char_valid, in_char_data, in_attr, output out_char_ready);
endinterface

interface text_vmem_if;
  import text_pkg::*;
  logic                 out_vmem_we;
  logic [ADDR_BITS-1:0] out_vmem_address;
  logic [15:0]          out_vmem_data;

  modport master (output out_vmem_we, out_vmem_address, out_vmem_data);
  modport slave  (input out_vmem_we, out_vmem_address, out_vmem_data);
endinterface

`default_nettype wire

// File: rtl/text_vram_writer.sv
// ============================================================================
// text_vram_writer : ASCII stream to text VRAM with cursor, wrap and ring scroll
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module text_vram_writer
  import text_pkg::*;
#(
  parameter logic [7:0] DEFAULT_ATTR = 8'h0F
) (
  input  wire logic                in_clock,
  input  wire logic                in_reset,
  text_char_if.slave               char_port,
  text_vmem_if.master              vmem_port,
  output logic [ROW_BITS-1:0]      out_top_row,
  output logic [COL_BITS-1:0]      out_cursor_col,
  output logic [ROW_BITS-1:0]      out_cursor_row,
  output logic                     out_busy
);

  localparam logic [15:0] C_BLANK = {DEFAULT_ATTR, BLANK_CHAR};

  state_t                           r_state, w_state;
  logic [ROW_BITS+COL_BITS-1:0]     r_cnt, w_cnt;
  logic [ROW_BITS-1:0]              r_clr_row, w_clr_row;
  logic [COL_BITS-1:0]              r_col, w_col;
  logic [ROW_BITS-1:0]              r_row, w_row;
  logic [ROW_BITS-1:0]              r_top, w_top;
  logic                             r_ready, w_ready;
  logic                             r_busy, w_busy;
  logic                             r_we, w_we;
  logic [ADDR_BITS-1:0]             r_addr, w_addr;
  logic [15:0]                      r_data, w_data;
  logic [ROW_BITS-1:0]              w_phys;
  logic                             w_accept;
  logic                             w_newline;
  logic [7:0]                       w_ch;

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      r_state   <= CLEAR_ALL;
      r_cnt     <= '0;
      r_clr_row <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_top     <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b1;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_clr_row <= w_clr_row;
      r_col     <= w_col;
      r_row     <= w_row;
      r_top     <= w_top;
      r_ready   <= w_ready;
      r_busy    <= w_busy;
      r_we      <= w_we;
      r_addr    <= w_addr;
      r_data    <= w_data;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_clr_row = r_clr_row;
    w_col     = r_col;
    w_row     = r_row;
    w_top     = r_top;
    w_ready   = r_ready;
    w_busy    = r_busy;
    w_we      = 1'b0;
    w_addr    = r_addr;
    w_data    = r_data;
    w_newline = 1'b0;
    w_ch      = char_port.in_char_data;
    w_phys    = r_top + r_row;
    w_accept  = char_port.in_char_valid && r_ready;

    case (r_state)
      CLEAR_ALL: begin
        w_we   = 1'b1;
        w_addr = vram_addr(r_cnt[ROW_BITS+COL_BITS-1:COL_BITS], r_cnt[COL_BITS-1:0]);
        w_data = C_BLANK;
        w_cnt  = r_cnt + 1'b1;
        if (r_cnt == (ROW_BITS+COL_BITS)'(CLEAR_WORDS - 1)) begin
          w_state = IDLE;
          w_ready = 1'b1;
          w_busy  = 1'b0;
        end
      end

      IDLE: begin
        if (w_accept) begin
          if (w_ch >= 8'h20 && w_ch <= 8'h7E) begin
            // Written at the pre-scroll position even when this wraps the screen.
            w_we   = 1'b1;
            w_addr = vram_addr(w_phys, r_col);
            w_data = pack_word(char_port.in_attr, w_ch);
            if (r_col == COL_BITS'(COLS - 1)) begin
              w_col     = '0;
              w_newline = 1'b1;
            end else begin
              w_col = r_col + 1'b1;
            end
          end else if (w_ch == CHAR_CR) begin
            w_col = '0;
          end else if (w_ch == CHAR_LF) begin
            w_col     = '0;
            w_newline = 1'b1;
          end else if (w_ch == CHAR_BS) begin
            if (r_col != '0) begin
              w_col  = r_col - 1'b1;
              w_we   = 1'b1;
              w_addr = vram_addr(w_phys, r_col - 1'b1);
              w_data = C_BLANK;
            end
          end

          if (w_newline) begin
            if (r_row != ROW_BITS'(ROWS - 1)) begin
              w_row = r_row + 1'b1;
            end else begin
              // Bottom row: advance the ring; the new bottom is old top + ROWS.
              w_top     = r_top + 1'b1;
              w_clr_row = r_top + ROW_BITS'(ROWS);
              w_cnt     = '0;
              w_state   = CLEAR_ROW;
              w_ready   = 1'b0;
              w_busy    = 1'b1;
            end
          end
        end
      end

      CLEAR_ROW: begin
        w_we   = 1'b1;
        w_addr = vram_addr(r_clr_row, r_cnt[COL_BITS-1:0]);
        w_data = C_BLANK;
        w_cnt  = r_cnt + 1'b1;
        if (r_cnt == (ROW_BITS+COL_BITS)'(COLS - 1)) begin
          w_state = IDLE;
          w_ready = 1'b1;
          w_busy  = 1'b0;
        end
      end

      default: begin
        w_state = CLEAR_ALL;
        w_cnt   = '0;
      end
    endcase
  end

  assign char_port.out_char_ready = r_ready;
  assign vmem_port.out_vmem_we      = r_we;
  assign vmem_port.out_vmem_address = r_addr;
  assign vmem_port.out_vmem_data    = r_data;
  assign out_top_row    = r_top;
  assign out_cursor_col = r_col;
  assign out_cursor_row = r_row;
  assign out_busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_text_vram_writer.sv
// ============================================================================
// tb_text_vram_writer : directed and randomized checks against a screen model
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_text_vram_writer;
  import text_pkg::*;

  logic       in_clock;
  logic       in_reset;
  logic [4:0] out_top_row;
  logic [6:0] out_cursor_col;
  logic [4:0] out_cursor_row;
  logic       out_busy;

  text_char_if cif ();
  text_vmem_if vif ();

  text_vram_writer dut (
    .in_clock       (in_clock),
    .in_reset       (in_reset),
    .char_port      (cif),
    .vmem_port      (vif),
    .out_top_row    (out_top_row),
    .out_cursor_col (out_cursor_col),
    .out_cursor_row (out_cursor_row),
    .out_busy       (out_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 0;

  logic [28:0] exp_q[$];
  logic [28:0] got_q[$];

  // Screen model: cursor, top row and the ordered list of expected VRAM writes.
  int m_col = 0;
  int m_row = 0;
  int m_top = 0;

  initial begin
    in_clock = 1'b0;
    forever #5 in_clock = ~in_clock;
  end

  always @(negedge in_clock) begin
    if (mon_en && vif.out_vmem_we)
      got_q.push_back({vif.out_vmem_address, vif.out_vmem_data});
  end

  function automatic void model_push(input int row, input int col, input logic [15:0] data);
    exp_q.push_back({13'(row * 128 + col), data});
  endfunction

  function automatic void model_newline();
    if (m_row < ROWS - 1) begin
      m_row++;
    end else begin
      m_top = (m_top + 1) % 32;
      for (int c = 0; c < COLS; c++)
        model_push((m_top + ROWS - 1) % 32, c, 16'h0F20);
    end
  endfunction

  function automatic void model_char(input logic [7:0] ch, input logic [7:0] at);
    int phys;
    phys = (m_top + m_row) % 32;
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      model_push(phys, m_col, {at, ch});
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        model_newline();
      end
    end else if (ch == 8'h0D) begin
      m_col = 0;
    end else if (ch == 8'h0A) begin
      m_col = 0;
      model_newline();
    end else if (ch == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        model_push(phys, m_col, 16'h0F20);
      end
    end
  endfunction

  // Presents one character and returns #1 after the edge that accepted it.
  task automatic send_char(input logic [7:0] ch, input logic [7:0] at);
    bit ok;
    ok = 0;
    cif.in_char_valid = 1'b1;
    cif.in_char_data  = ch;
    cif.in_attr       = at;
    for (int i = 0; i < 500; i++) begin
      if (cif.out_char_ready) begin
        ok = 1;
        break;
      end
      @(posedge in_clock); #1;
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: ready=%0b required 1", cif.out_char_ready);
    end else begin
      @(posedge in_clock); #1;
      model_char(ch, at);
    end
  endtask

  task automatic drain();
    cif.in_char_valid = 1'b0;
    for (int i = 0; i < 500 && !cif.out_char_ready; i++) begin
      @(posedge in_clock); #1;
    end
    repeat (3) @(negedge in_clock);
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    in_reset = 1'b1;
    cif.in_char_valid = 1'b0;
    cif.in_char_data  = 8'h00;
    cif.in_attr       = 8'h00;
    repeat (3) @(posedge in_clock);
    @(negedge in_clock);
    n_checks++;
    if ({vif.out_vmem_we, vif.out_vmem_address, vif.out_vmem_data} !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_vmem: got we=%0b addr=%0d data=%h required 0/0/0000",
               vif.out_vmem_we, vif.out_vmem_address, vif.out_vmem_data);
    end
    n_checks++;
    if ({cif.out_char_ready, out_busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_flags: got ready=%0b busy=%0b required 0/1", cif.out_char_ready, out_busy);
    end
    n_checks++;
    if ({out_top_row, out_cursor_row, out_cursor_col} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_cursor: got top=%0d row=%0d col=%0d required 0/0/0",
               out_top_row, out_cursor_row, out_cursor_col);
    end
    in_reset = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      @(negedge in_clock);
      if (bad == 0 && (vif.out_vmem_we !== 1'b1 || vif.out_vmem_address !== 13'(i) ||
                       vif.out_vmem_data !== 16'h0F20)) begin
        bad = 1;
        $display("FAIL clear_all_sweep: step %0d got we=%0b addr=%0d data=%h required 1/%0d/0f20",
                 i, vif.out_vmem_we, vif.out_vmem_address, vif.out_vmem_data, i);
      end
    end
    n_checks++;
    n_fail += bad;
    n_checks++;
    if ({cif.out_char_ready, out_busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL clear_all_done: got ready=%0b busy=%0b required 1/0", cif.out_char_ready, out_busy);
    end
    @(negedge in_clock);
    n_checks++;
    if (vif.out_vmem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_all_stop: got we=%0b required 0", vif.out_vmem_we);
    end
    m_col = 0; m_row = 0; m_top = 0;
    mon_en = 1;
  endtask

  task automatic test_single_char();
    send_char(8'h41, 8'h1E);
    n_checks++;
    if ({vif.out_vmem_we, vif.out_vmem_address, vif.out_vmem_data} !== {1'b1, 13'd0, 16'h1E41}) begin
      n_fail++;
      $display("FAIL single_write: got we=%0b addr=%0d data=%h required 1/0/1e41",
               vif.out_vmem_we, vif.out_vmem_address, vif.out_vmem_data);
    end
    n_checks++;
    if (out_cursor_col !== 7'd1) begin
      n_fail++;
      $display("FAIL single_cursor: got col=%0d required 1", out_cursor_col);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    send_char(8'h0D, 8'h00);
    exp_q.delete(); got_q.delete();
    for (int i = 0; i < 80; i++) send_char(8'h78, 8'h07);
    n_checks++;
    if ({out_cursor_row, out_cursor_col} !== {5'd1, 7'd0}) begin
      n_fail++;
      $display("FAIL row_wrap_cursor: got row=%0d col=%0d required 1/0", out_cursor_row, out_cursor_col);
    end
    send_char(8'h42, 8'h07);
    drain();
    n_checks++;
    if (got_q.size() != 81) begin
      n_fail++;
      $display("FAIL row_write_count: got %0d required 81", got_q.size());
    end else begin
      for (int i = 0; i < 81; i++) begin
        logic [28:0] want;
        want = (i < 80) ? {13'(i), 16'h0778} : {13'd128, 16'h0742};
        n_checks++;
        if (got_q[i] !== want) begin
          n_fail++;
          $display("FAIL row_write[%0d]: got addr=%0d data=%h required addr=%0d data=%h",
                   i, got_q[i][28:16], got_q[i][15:0], want[28:16], want[15:0]);
        end
      end
    end
  endtask

  task automatic test_scroll();
    int n;
    send_char(8'h0D, 8'h00);
    for (int i = 0; i < 28; i++) send_char(8'h0A, 8'h00);
    drain();
    exp_q.delete(); got_q.delete();
    send_char(8'h0A, 8'h00);
    n_checks++;
    if ({out_top_row, out_cursor_row, out_cursor_col, cif.out_char_ready, out_busy} !==
        {5'd1, 5'd29, 7'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL scroll_state: got top=%0d row=%0d col=%0d ready=%0b busy=%0b required 1/29/0/0/1",
               out_top_row, out_cursor_row, out_cursor_col, cif.out_char_ready, out_busy);
    end
    n = 0;
    while (!cif.out_char_ready && n < 300) begin
      n++;
      @(posedge in_clock); #1;
    end
    n_checks++;
    if (n != 80) begin
      n_fail++;
      $display("FAIL scroll_ready_low: got %0d cycles required 80", n);
    end
    cif.in_char_valid = 1'b0;
    repeat (3) @(negedge in_clock);
    n_checks++;
    if (got_q.size() != 80) begin
      n_fail++;
      $display("FAIL scroll_clear_count: got %0d required 80", got_q.size());
    end else begin
      for (int i = 0; i < 80; i++) begin
        n_checks++;
        if (got_q[i] !== {13'(3840 + i), 16'h0F20}) begin
          n_fail++;
          $display("FAIL scroll_clear[%0d]: got addr=%0d data=%h required addr=%0d data=0f20",
                   i, got_q[i][28:16], got_q[i][15:0], 3840 + i);
        end
      end
    end
    send_char(8'h41, 8'h1E);
    n_checks++;
    if ({vif.out_vmem_we, vif.out_vmem_address, vif.out_vmem_data} !== {1'b1, 13'd3840, 16'h1E41}) begin
      n_fail++;
      $display("FAIL post_scroll_write: got we=%0b addr=%0d data=%h required 1/3840/1e41",
               vif.out_vmem_we, vif.out_vmem_address, vif.out_vmem_data);
    end
    drain();
  endtask

  task automatic test_backspace();
    send_char(8'h0D, 8'h00);
    send_char(8'h08, 8'h00);
    n_checks++;
    if ({vif.out_vmem_we, out_cursor_col} !== {1'b0, 7'd0}) begin
      n_fail++;
      $display("FAIL bs_col0: got we=%0b col=%0d required 0/0", vif.out_vmem_we, out_cursor_col);
    end
    send_char(8'h61, 8'h02);
    send_char(8'h62, 8'h02);
    send_char(8'h63, 8'h02);
    send_char(8'h08, 8'h00);
    n_checks++;
    if ({vif.out_vmem_we, vif.out_vmem_address, vif.out_vmem_data, out_cursor_col} !==
        {1'b1, 13'd3842, 16'h0F20, 7'd2}) begin
      n_fail++;
      $display("FAIL bs_erase: got we=%0b addr=%0d data=%h col=%0d required 1/3842/0f20/2",
               vif.out_vmem_we, vif.out_vmem_address, vif.out_vmem_data, out_cursor_col);
    end
    drain();
  endtask

  task automatic test_random();
    logic [7:0] ch;
    int r;
    exp_q.delete(); got_q.delete();
    // Fill to the end of the bottom row so the last printable forces a scroll.
    send_char(8'h0D, 8'h00);
    for (int i = 0; i < 80; i++) send_char(8'(32 + $urandom_range(0, 94)), 8'($urandom));
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      ch = 8'($urandom_range(32, 126));
      else if (r < 78) ch = 8'h0D;
      else if (r < 86) ch = 8'h0A;
      else if (r < 95) ch = 8'h08;
      else             ch = 8'(128 + $urandom_range(0, 127));
      if ($urandom_range(0, 3) == 0) begin
        cif.in_char_valid = 1'b0;
        @(posedge in_clock); #1;
      end
      send_char(ch, 8'($urandom));
      n_checks++;
      if ({out_top_row, out_cursor_row, out_cursor_col} !== {5'(m_top), 5'(m_row), 7'(m_col)}) begin
        n_fail++;
        $display("FAIL rand_cursor[%0d]: got top=%0d row=%0d col=%0d required %0d/%0d/%0d",
                 i, out_top_row, out_cursor_row, out_cursor_col, m_top, m_row, m_col);
      end
    end
    drain();
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_write_count: got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rand_write[%0d]: got addr=%0d data=%h required addr=%0d data=%h",
                 i, got_q[i][28:16], got_q[i][15:0], exp_q[i][28:16], exp_q[i][15:0]);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    // Cursor sits on the bottom row here, so a LF starts a row clear.
    send_char(8'h0D, 8'h00);
    for (int i = 0; i < 30; i++) send_char(8'h0A, 8'h00);
    cif.in_char_valid = 1'b0;
    repeat (10) @(posedge in_clock);
    #1;
    n_checks++;
    if ({out_busy, vif.out_vmem_we} !== 2'b11) begin
      n_fail++;
      $display("FAIL mid_clear_active: got busy=%0b we=%0b required 1/1", out_busy, vif.out_vmem_we);
    end
    mon_en = 0;
    in_reset = 1'b1;
    @(posedge in_clock); #1;
    n_checks++;
    if ({vif.out_vmem_we, out_top_row, out_cursor_row, out_cursor_col, out_busy, cif.out_char_ready} !==
        {1'b0, 5'd0, 5'd0, 7'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_reset: got we=%0b top=%0d row=%0d col=%0d busy=%0b ready=%0b required 0/0/0/0/1/0",
               vif.out_vmem_we, out_top_row, out_cursor_row, out_cursor_col, out_busy, cif.out_char_ready);
    end
    in_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge in_clock); #1;
      n_checks++;
      if ({vif.out_vmem_we, vif.out_vmem_address, vif.out_vmem_data} !== {1'b1, 13'(i), 16'h0F20}) begin
        n_fail++;
        $display("FAIL restart_clear[%0d]: got we=%0b addr=%0d data=%h required 1/%0d/0f20",
                 i, vif.out_vmem_we, vif.out_vmem_address, vif.out_vmem_data, i);
      end
    end
  endtask

  initial begin
    in_reset = 1'b1;
    cif.in_char_valid = 1'b0;
    cif.in_char_data  = 8'h00;
    cif.in_attr       = 8'h00;
    test_reset();
    test_single_char();
    test_back_to_back();
    test_scroll();
    test_backspace();
    test_random();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/text_vram_writer.md
Name: text_vram_writer

Overview:
Character-stream writer for the text VRAM that the VGA controller scans out. It accepts ASCII bytes over a valid/ready handshake and tracks a cursor. It performs wrap, CR/LF, backspace and hardware scrolling, and writes {attr, char} words into the VRAM write port. Scrolling is a circular row buffer: the block publishes a top-row offset that the display path adds to its row index, so no VRAM copy is needed.

Parameters:
COLS, 80, visible columns per row
ROWS, 30, visible rows (640x480, 8x16 font)
COL_BITS, 7, column address bits (row stride 128 words)
ROW_BITS, 5, physical row bits (32 physical rows, 4096 words)
DEFAULT_ATTR, 8'h0F, attribute used for blank fill

Ports:
in_clock  input  1  system clock
in_reset  input  1  synchronous reset, active-high
in_char_valid  input  1  character available
in_char_data  input  8  ASCII code
in_attr  input  8  attribute for printable characters, sampled with char
out_char_ready  output  1  block can accept a character this cycle
out_vmem_we  output  1  VRAM write strobe, one word per cycle
out_vmem_address  output  13  VRAM word address, {1'b0, phys_row[4:0], col[6:0]}
out_vmem_data  output  16  {attr[7:0], char[7:0]}
out_top_row  output  5  physical row shown as screen row 0
out_cursor_col  output  7  logical cursor column 0..COLS-1
out_cursor_row  output  5  logical cursor row 0..ROWS-1
out_busy  output  1  high in CLEAR_ALL or CLEAR_ROW

Behaviour:
- Reset (sync, any state): state=CLEAR_ALL, clear counter=0, cursor=(0,0), out_top_row=0, out_char_ready=0, out_vmem_we=0, out_vmem_address=0, out_vmem_data=0, out_busy=1.
- All outputs are registered. Definitions: blank word = {DEFAULT_ATTR, 8'h20}; phys_row = (out_top_row + cursor_row) mod 32.
- CLEAR_ALL:
  - One write per cycle, addresses 0..4095, data = blank word.
  - After address 4095 is written, go to IDLE and assert out_char_ready.
- IDLE:
  - out_char_ready=1. A character is accepted on an edge where in_char_valid && out_char_ready.
  - Write latency: the write for a character accepted at edge N is presented during cycle N+1, with out_vmem_we=1 for exactly one cycle.
  - The cursor and out_top_row update at edge N.
  - Throughput is one character per cycle when no scroll occurs.
- Character handling:
  - 0x20..0x7E: write {in_attr, char} at {phys_row, col}. Then col+1. If the result equals COLS, set col=0 and perform a newline.
  - 0x0D (CR): col=0, no write.
  - 0x0A (LF): col=0 and newline, no write.
  - 0x08 (BS): if col>0, col-1 and write the blank word at the new col. If col==0, no write and no cursor change.
  - Any other code: consumed with no write and no state change.
- Newline:
  - If cursor_row < ROWS-1: cursor_row+1.
  - Otherwise cursor_row stays ROWS-1, out_top_row = out_top_row+1 mod 32, and the FSM enters CLEAR_ROW targeting phys row (new top + ROWS-1) mod 32.
  - A printable character at the last column of the last row is still written at its original position (pre-scroll address) before the clear begins.
- CLEAR_ROW:
  - out_char_ready=0.
  - COLS consecutive writes of the blank word to cols 0..COLS-1 of the target row, then return to IDLE.
  - Cols COLS..127 are never written after CLEAR_ALL.
- Column/row arithmetic: out_top_row and phys_row wrap modulo 32 naturally via the 5-bit width; no saturation.
- Boundary cases:
  - Valid held while ready=0 is ignored; the source must hold data until accepted.
  - Reset during CLEAR_ALL or CLEAR_ROW aborts immediately and restarts CLEAR_ALL from address 0.
  - The visible cleared row may show stale content for at most COLS cycles after a scroll; this is accepted.

Decomposition:
- Shared package text_pkg holds:
  - COLS, ROWS, COL_BITS, ROW_BITS, and VRAM_WORDS=8192
  - BLANK_CHAR=8'h20
  - control codes CR/LF/BS
  - state enum {CLEAR_ALL, IDLE, CLEAR_ROW}
  - the word-packing function {attr, char}
- The display side also uses the package, for row stride and the top-row add.
- No sub-module: a single FSM plus one shared clear counter. The address mux is inline.

Test Plan:
- Release reset → out_vmem_we high for 4096 consecutive cycles, addresses 0..4095, data 16'h0F20; then out_char_ready=1, out_busy=0.
- Send 0x41 with attr 8'h1E → next cycle we=1, address 0, data 16'h1E41; out_cursor_col=1.
- Send 80 × 0x78 back-to-back → writes to addresses 0..79 on consecutive cycles; cursor=(row1,col0); the next printable character lands at address 128.
- Advance the cursor to row 29, then send 0x0A → out_top_row=1, ready low for 80 cycles, writes to 3840..3919 with data 16'h0F20. The next 0x41 is written to address 3840.
- 0x08 at col 0 → no write, cursor unchanged. Print 3 characters then 0x08 → blank word written at col 2, out_cursor_col=2.
- Assert in_reset mid-CLEAR_ROW → next cycle out_vmem_we=0, out_top_row=0, cursor (0,0). The CLEAR_ALL sequence restarts at address 0.
